// File: rtl/alu_pkg.sv
// Shared types and defaults for the lab ALU datapath and its multiply controller.
package alu_pkg;

    localparam int ALU_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/alu_add4n.sv
// Parameterized N-bit ripple-carry adder built from a chain of full-adder cells.
module alu_add4n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    logic [N:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[N];

endmodule

// File: rtl/alu_mult_ctrl.sv
// Shift-and-add unsigned multiplier: one N-bit adder sequenced over N steps into a 2N-bit product.
module alu_mult_ctrl
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           Ready,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] Product,
    output mult_state_t    dbg_state
);

    // Handshake: a request is accepted on the rising edge where Start=1 and Ready=1;
    // Start in any other state is dropped, and Done pulses once when Product is valid.

    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mult_state_t    state;
    mult_state_t    state_nxt;
    logic [N-1:0]   m_r;
    logic [N-1:0]   q_r;
    logic [N-1:0]   p_r;
    logic [CW-1:0]  cnt_r;
    logic [2*N-1:0] product_r;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_s;
    logic           add_c;
    logic           accept;
    logic           calc_step;
    logic           calc_last;

    assign accept    = (state == IDLE) && Start;
    assign calc_step = (state == CALC);
    assign calc_last = calc_step && (cnt_r == LAST);

    // Gating the addend with Q[0] makes the no-add case fall out as {0,P}.
    assign add_b = q_r[0] ? m_r : '0;

    alu_add4n #(
        .N(N)
    ) u_add (
        .a    (p_r),
        .b    (add_b),
        .c_in (1'b0),
        .s    (add_s),
        .c_out(add_c)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (cnt_r == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_r       <= '0;
            q_r       <= '0;
            p_r       <= '0;
            cnt_r     <= '0;
            product_r <= '0;
        end else if (accept) begin
            m_r   <= A;
            q_r   <= B;
            p_r   <= '0;
            cnt_r <= '0;
        end else if (calc_step) begin
            // Carry out becomes the new MSB of P so the full 2N-bit product survives.
            p_r   <= {add_c, add_s[N-1:1]};
            q_r   <= {add_s[0], q_r[N-1:1]};
            cnt_r <= cnt_r + 1'b1;
            if (calc_last) begin
                product_r <= {add_c, add_s, q_r[N-1:1]};
            end
        end
    end

    assign Ready     = (state == IDLE);
    assign Busy      = (state == CALC);
    assign Done      = (state == DONE);
    assign Product   = product_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Self-checking bench for alu_mult_ctrl: vector table, corner sequences, held-Start soak.
module tb_alu_mult_ctrl;
  import alu_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
  } vec_t;

  logic           Clock;
  logic           Reset;
  logic           Start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           Ready;
  logic           Busy;
  logic           Done;
  logic [2*N-1:0] Product;
  mult_state_t    dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int last_done = 0;
  bit have_last = 0;
  bit held_mode = 0;
  logic [2*N-1:0] exp_q[$];

  alu_mult_ctrl #(.N(N)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Ready    (Ready),
    .Busy     (Busy),
    .Done     (Done),
    .Product  (Product),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: act=%0h req=%0h", name, act, exp);
  endtask

  // scoreboard: every Done pops one expected product
  always @(negedge Clock) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(1), 32'(0));
      end else begin
        check("product", 32'(Product), 32'(exp_q.pop_front()));
      end
      if (held_mode && have_last) check("done_spacing", 32'(cyc - last_done), 32'(N + 2));
      last_done = cyc;
      have_last = 1'b1;
    end
  end

  // driver: launch one op, scramble operands afterwards, optionally poke Start in CALC/DONE
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input bit poke_calc, input bit poke_done);
    int busy_n, done_n, done_at, rdy_low, k;
    @(negedge Clock);
    check("ready_before", 32'(Ready), 32'(1));
    A = a; B = b; Start = 1'b1;
    @(posedge Clock);
    exp_q.push_back(exp);
    @(negedge Clock);
    busy_n = 0; done_n = 0; done_at = -1; rdy_low = 0; k = 1;
    while (k <= 20 && !Ready) begin
      if (Busy) busy_n++;
      if (Done) begin done_n++; done_at = k; end
      rdy_low++;
      Start = 1'b0;
      A = N'($urandom_range(0, (1 << N) - 1));
      B = N'($urandom_range(0, (1 << N) - 1));
      if ((poke_calc && k == 2) || (poke_done && k == N + 1)) begin
        Start = 1'b1; A = 1; B = 1;
      end
      @(negedge Clock);
      k++;
    end
    Start = 1'b0;
    check("busy_cycles", 32'(busy_n), 32'(N));
    check("done_pulses", 32'(done_n), 32'(1));
    check("done_latency", 32'(done_at), 32'(N + 1));
    check("ready_low_cycles", 32'(rdy_low), 32'(N + 1));
  endtask

  initial begin
    vec_t vecs[6];
    logic [N-1:0] ha, hb;
    vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 8'h0F};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  exp: 8'h00};
    vecs[3] = '{a: 4'd12, b: 4'd0,  exp: 8'h00};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  exp: 8'h01};
    vecs[5] = '{a: 4'd9,  b: 4'd14, exp: 8'h7E};

    Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge Clock);
    check("rst_ready", 32'(Ready), 32'(1));
    check("rst_busy", 32'(Busy), 32'(0));
    check("rst_done", 32'(Done), 32'(0));
    check("rst_product", 32'(Product), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b0);

    // extra Starts during CALC and DONE must be ignored
    run_op(4'd12, 4'd10, 8'h78, 1'b1, 1'b1);
    repeat (N + 3) @(negedge Clock);
    check("no_requeue_ready", 32'(Ready), 32'(1));
    check("product_held", 32'(Product), 32'(8'h78));

    // reset two cycles into CALC
    @(negedge Clock);
    A = 4'd7; B = 4'd6; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    check("pre_reset_busy", 32'(Busy), 32'(1));
    Reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(Ready), 32'(1));
    check("mid_rst_busy", 32'(Busy), 32'(0));
    check("mid_rst_done", 32'(Done), 32'(0));
    check("mid_rst_product", 32'(Product), 32'(0));
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge Clock);
    Reset = 1'b0;
    run_op(4'd2, 4'd2, 8'h04, 1'b0, 1'b0);

    // Start held high: new op every N+2 cycles, operands scrambled while busy
    held_mode = 1'b1;
    have_last = 1'b0;
    for (int op = 0; op < 1000; op++) begin
      @(negedge Clock);
      ha = N'($urandom_range(0, (1 << N) - 1));
      hb = N'($urandom_range(0, (1 << N) - 1));
      A = ha; B = hb; Start = 1'b1;
      @(posedge Clock);
      exp_q.push_back((2*N)'(ha) * (2*N)'(hb));
      for (int j = 0; j < N + 1; j++) begin
        @(negedge Clock);
        A = N'($urandom_range(0, (1 << N) - 1));
        B = N'($urandom_range(0, (1 << N) - 1));
      end
    end
    @(negedge Clock);
    Start = 1'b0;
    repeat (N + 4) @(negedge Clock);
    held_mode = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("final_ready", 32'(Ready), 32'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
